// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, drives the instruction memory
// address and registers the fetched word into the IF/ID bundle.
//
// Ports:
//   clk, rst_n       - clock, async active-low reset
//   stall            - hold PC, IF/ID and fetch_count
//   redirect_en      - flush IF/ID and load PC from redirect_target
//   redirect_target  - new fetch address (low two bits dropped)
//   inst_data        - word returned by imem for inst_addr (same cycle)
//   inst_addr        - fetch address, equals the PC register
//   if_id_inst       - registered instruction for decode
//   if_id_pc         - address of if_id_inst
//   if_id_pc_plus4   - if_id_pc + PC_STEP
//   if_id_valid      - IF/ID holds a real fetched instruction
//   fetch_count      - number of valid writes into IF/ID (wraps)
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000,
    parameter int          PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect_en,
    input  logic [31:0] redirect_target,
    input  logic [31:0] inst_data,
    output logic [31:0] inst_addr,
    output logic [31:0] if_id_inst,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc_plus4,
    output logic        if_id_valid,
    output logic [31:0] fetch_count
);

    localparam logic [31:0] STEP = 32'(PC_STEP);

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic        valid;
    } if_id_t;

    logic [31:0] pc;
    logic [31:0] pc_next_seq;
    logic [31:0] cnt;
    if_id_t      if_id;

    assign pc_next_seq = pc + STEP;

    // Redirect beats stall: the held instruction is dropped, not replayed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc             <= RESET_PC;
            if_id.inst     <= NOP_INST;
            if_id.pc       <= '0;
            if_id.pc_plus4 <= '0;
            if_id.valid    <= 1'b0;
            cnt            <= '0;
        end else if (redirect_en) begin
            pc             <= {redirect_target[31:2], 2'b00};
            if_id.inst     <= NOP_INST;
            if_id.pc       <= '0;
            if_id.pc_plus4 <= '0;
            if_id.valid    <= 1'b0;
        end else if (!stall) begin
            pc             <= pc_next_seq;
            if_id.inst     <= inst_data;
            if_id.pc       <= pc;
            if_id.pc_plus4 <= pc_next_seq;
            if_id.valid    <= 1'b1;
            cnt            <= cnt + 32'd1;
        end
    end

    assign inst_addr      = pc;
    assign if_id_inst     = if_id.inst;
    assign if_id_pc       = if_id.pc;
    assign if_id_pc_plus4 = if_id.pc_plus4;
    assign if_id_valid    = if_id.valid;
    assign fetch_count    = cnt;

endmodule
